// File: rtl/fma_write_buffer.sv
// rtl/fma_write_buffer.sv - packs per-lane FMA results into memory lines and queues them
// The head line is presented combinationally from storage at the read pointer.
module fma_write_buffer #(
   parameter int FMA_COUNT  = 2,
   parameter int WORD_WIDTH = 16,
   parameter int LINE_WIDTH = 96,
   parameter int DEPTH      = 4
) (
   input  logic                            clk_in,
   input  logic                            rst_in,
   input  logic [FMA_COUNT*WORD_WIDTH-1:0] fma_c_in,
   input  logic [FMA_COUNT-1:0]            fma_valid_in,
   input  logic                            fma_output_can_be_valid_in,
   input  logic                            line_pop_in,
   input  logic                            flush_in,
   output logic [LINE_WIDTH-1:0]           write_buffer_read_out,
   output logic                            write_buffer_valid_out,
   output logic [$clog2(DEPTH+1)-1:0]      count_out,
   output logic                            full_out,
   output logic                            overflow_out,
   output logic                            conflict_out
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [FMA_COUNT-1:0]  got;
   logic [FMA_COUNT-1:0]  accepted;
   logic [FMA_COUNT-1:0]  merged_mask;
   logic [WORD_WIDTH-1:0] words [FMA_COUNT];
   logic [WORD_WIDTH-1:0] merged [FMA_COUNT];
   logic [LINE_WIDTH-1:0] line;
   logic [LINE_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr;
   logic [CW-1:0]         count;
   logic                  push;
   logic                  pop;
   logic                  full;
   logic                  push_ok;

   always_comb begin
      accepted    = fma_valid_in & {FMA_COUNT{fma_output_can_be_valid_in}};
      merged_mask = got | accepted;
      push        = &merged_mask;
      line        = '0;
      // Same-cycle words win over stored ones so a completing line carries them.
      for (int i = 0; i < FMA_COUNT; i++) begin
         merged[i] = accepted[i] ? fma_c_in[i*WORD_WIDTH +: WORD_WIDTH] : words[i];
         line[LINE_WIDTH-1-(3*i+2)*WORD_WIDTH -: WORD_WIDTH] = merged[i];
      end
      full    = (count == CW'(DEPTH));
      pop     = line_pop_in && (count != '0);
      push_ok = push && (!full || pop);
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         got          <= '0;
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= '0;
         overflow_out <= 1'b0;
         conflict_out <= 1'b0;
         for (int i = 0; i < FMA_COUNT; i++) words[i] <= '0;
         for (int d = 0; d < DEPTH; d++) mem[d] <= '0;
      end else if (flush_in) begin
         got    <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         got <= push ? '0 : merged_mask;
         for (int i = 0; i < FMA_COUNT; i++) begin
            if (accepted[i]) words[i] <= fma_c_in[i*WORD_WIDTH +: WORD_WIDTH];
         end
         if (|(accepted & got)) conflict_out <= 1'b1;
         // When full with a pop, wr_ptr equals rd_ptr: the new line takes the popped slot.
         if (push_ok) begin
            mem[wr_ptr] <= line;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (push && !push_ok) overflow_out <= 1'b1;
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push_ok) - CW'(pop);
      end
   end

   assign write_buffer_read_out  = mem[rd_ptr];
   assign write_buffer_valid_out = (count != '0);
   assign count_out              = count;
   assign full_out               = full;
endmodule

// File: tb/tb_fma_write_buffer.sv
// tb/tb_fma_write_buffer.sv - directed self-checking bench for fma_write_buffer
module tb_fma_write_buffer;
   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [31:0] fma_c_in;
   logic [1:0]  fma_valid_in;
   logic        fma_output_can_be_valid_in;
   logic        line_pop_in;
   logic        flush_in;
   logic [95:0] write_buffer_read_out;
   logic        write_buffer_valid_out;
   logic [2:0]  count_out;
   logic        full_out;
   logic        overflow_out;
   logic        conflict_out;

   int checks = 0;
   int failures = 0;

   fma_write_buffer #(.FMA_COUNT(2), .WORD_WIDTH(16), .LINE_WIDTH(96), .DEPTH(4)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .fma_c_in(fma_c_in), .fma_valid_in(fma_valid_in),
      .fma_output_can_be_valid_in(fma_output_can_be_valid_in), .line_pop_in(line_pop_in),
      .flush_in(flush_in), .write_buffer_read_out(write_buffer_read_out),
      .write_buffer_valid_out(write_buffer_valid_out), .count_out(count_out),
      .full_out(full_out), .overflow_out(overflow_out), .conflict_out(conflict_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [95:0] actual, input logic [95:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   // Expected layout: lane0 c in word 2, lane1 c in word 5, a/b words zero.
   function automatic logic [95:0] mk_line(input logic [15:0] l0, input logic [15:0] l1);
      return {16'h0, 16'h0, l0, 16'h0, 16'h0, l1};
   endfunction

   task automatic drive(input logic [1:0] v, input logic [31:0] c, input logic can,
                        input logic pop, input logic fl);
      fma_valid_in = v;
      fma_c_in = c;
      fma_output_can_be_valid_in = can;
      line_pop_in = pop;
      flush_in = fl;
      @(posedge clk_in);
      #1;
      fma_valid_in = '0;
      fma_c_in = '0;
      fma_output_can_be_valid_in = 1'b1;
      line_pop_in = 1'b0;
      flush_in = 1'b0;
   endtask

   task automatic push_line(input logic [15:0] l0, input logic [15:0] l1, input logic pop);
      drive(2'b11, {l1, l0}, 1'b1, pop, 1'b0);
   endtask

   initial begin
      rst_in = 1'b0;
      fma_c_in = 32'h1234_5678;
      fma_valid_in = 2'b11;
      fma_output_can_be_valid_in = 1'b1;
      line_pop_in = 1'b0;
      flush_in = 1'b0;
      #30;
      check("in_reset_count", 96'(count_out), 96'd0);
      check("in_reset_valid", 96'(write_buffer_valid_out), 96'd0);
      fma_valid_in = '0;
      fma_c_in = '0;
      #3 rst_in = 1'b1;
      @(posedge clk_in);
      #1;
      check("rst_valid", 96'(write_buffer_valid_out), 96'd0);
      check("rst_count", 96'(count_out), 96'd0);
      check("rst_full", 96'(full_out), 96'd0);
      check("rst_read", write_buffer_read_out, 96'd0);
      check("rst_ovf", 96'(overflow_out), 96'd0);
      check("rst_cnf", 96'(conflict_out), 96'd0);

      // Single line, both lanes together
      drive(2'b11, {16'h0002, 16'h0001}, 1'b1, 1'b0, 1'b0);
      check("single_valid", 96'(write_buffer_valid_out), 96'd1);
      check("single_read", write_buffer_read_out, 96'h0000_0000_0001_0000_0000_0002);
      check("single_count", 96'(count_out), 96'd1);
      drive(2'b00, 32'h0, 1'b1, 1'b1, 1'b0);
      check("single_pop_valid", 96'(write_buffer_valid_out), 96'd0);

      // Staggered lanes and gated strobes
      drive(2'b01, {16'h0000, 16'h00AA}, 1'b1, 1'b0, 1'b0);
      check("stag_partial", 96'(count_out), 96'd0);
      drive(2'b00, 32'h0, 1'b1, 1'b0, 1'b0);
      drive(2'b10, {16'h0077, 16'h0000}, 1'b0, 1'b0, 1'b0);
      check("stag_gated", 96'(count_out), 96'd0);
      drive(2'b10, {16'h00BB, 16'h0000}, 1'b1, 1'b0, 1'b0);
      check("stag_count", 96'(count_out), 96'd1);
      check("stag_read", write_buffer_read_out, 96'h0000_0000_00AA_0000_0000_00BB);
      check("stag_no_cnf", 96'(conflict_out), 96'd0);
      drive(2'b00, 32'h0, 1'b1, 1'b1, 1'b0);
      drive(2'b01, {16'h0000, 16'h0011}, 1'b1, 1'b0, 1'b0);
      drive(2'b01, {16'h0000, 16'h0022}, 1'b1, 1'b0, 1'b0);
      check("cnf_set", 96'(conflict_out), 96'd1);
      check("cnf_no_line", 96'(count_out), 96'd0);
      drive(2'b10, {16'h0033, 16'h0000}, 1'b1, 1'b0, 1'b0);
      check("cnf_newer_kept", write_buffer_read_out, mk_line(16'h0022, 16'h0033));
      drive(2'b00, 32'h0, 1'b1, 1'b1, 1'b0);
      check("cnf_pop_count", 96'(count_out), 96'd0);

      // Full and overflow
      for (int k = 1; k <= 4; k++) push_line(16'h0A00 + 16'(k), 16'h0B00 + 16'(k), 1'b0);
      check("full_flag", 96'(full_out), 96'd1);
      check("full_count", 96'(count_out), 96'd4);
      check("full_no_ovf", 96'(overflow_out), 96'd0);
      push_line(16'h0A05, 16'h0B05, 1'b0);
      check("ovf_flag", 96'(overflow_out), 96'd1);
      check("ovf_count", 96'(count_out), 96'd4);
      check("ovf_head", write_buffer_read_out, mk_line(16'h0A01, 16'h0B01));
      for (int k = 1; k <= 4; k++) begin
         check("ovf_order", write_buffer_read_out, mk_line(16'h0A00 + 16'(k), 16'h0B00 + 16'(k)));
         drive(2'b00, 32'h0, 1'b1, 1'b1, 1'b0);
      end
      check("ovf_drained", 96'(write_buffer_valid_out), 96'd0);

      // Full with simultaneous push and pop
      for (int k = 6; k <= 9; k++) push_line(16'h0C00 + 16'(k), 16'h0D00 + 16'(k), 1'b0);
      push_line(16'h0C0A, 16'h0D0A, 1'b1);
      check("pp_count", 96'(count_out), 96'd4);
      check("pp_full", 96'(full_out), 96'd1);
      for (int k = 7; k <= 10; k++) begin
         check("pp_order", write_buffer_read_out, mk_line(16'h0C00 + 16'(k), 16'h0D00 + 16'(k)));
         drive(2'b00, 32'h0, 1'b1, 1'b1, 1'b0);
      end
      check("pp_drained", 96'(count_out), 96'd0);

      // Flush with a same-cycle push and pop
      push_line(16'h0E01, 16'h0F01, 1'b0);
      push_line(16'h0E02, 16'h0F02, 1'b0);
      drive(2'b01, {16'h0000, 16'h0E03}, 1'b1, 1'b0, 1'b0);
      check("pre_flush_count", 96'(count_out), 96'd2);
      drive(2'b11, {16'h0F04, 16'h0E04}, 1'b1, 1'b1, 1'b1);
      check("flush_count", 96'(count_out), 96'd0);
      check("flush_valid", 96'(write_buffer_valid_out), 96'd0);
      check("flush_full", 96'(full_out), 96'd0);
      drive(2'b10, {16'h0F05, 16'h0000}, 1'b1, 1'b0, 1'b0);
      check("flush_mask_clear", 96'(count_out), 96'd0);
      check("flush_keep_ovf", 96'(overflow_out), 96'd1);
      check("flush_keep_cnf", 96'(conflict_out), 96'd1);

      // Reset mid-assembly discards the partial lane 1 word
      #2 rst_in = 1'b0;
      #3 rst_in = 1'b1;
      check("rst2_ovf", 96'(overflow_out), 96'd0);
      drive(2'b01, {16'h0000, 16'h0E06}, 1'b1, 1'b0, 1'b0);
      check("rst2_partial_gone", 96'(count_out), 96'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fma_write_buffer.md
# fma_write_buffer

Collects per-FMA results from the FMA array and packs them into memory-line format. Queues completed lines in a small FIFO and presents the head line to the `memory` block on its `write_buffer_read_in` / `write_buffer_valid_in` inputs. Sits between the FMA array (producer) and `memory` (consumer, which pops a line when it executes a store-from-write-buffer instruction).

## Interface

**Parameters**
- `FMA_COUNT`, default 2: number of FMA lanes.
- `WORD_WIDTH`, default 16: bits per word.
- `LINE_WIDTH`, default 96: must equal FMA_COUNT*3*WORD_WIDTH.
- `DEPTH`, default 4: FIFO depth in lines. Power of two, ≥2.

**Ports**
- `clk_in` input 1: single clock; all state changes on its rising edge.
- `rst_in` input 1: asynchronous, active-low reset.
- `fma_c_in` input FMA_COUNT*WORD_WIDTH: lane i result at bits [(i+1)*WORD_WIDTH-1 : i*WORD_WIDTH].
- `fma_valid_in` input FMA_COUNT: per-lane result strobe.
- `fma_output_can_be_valid_in` input 1: from `memory`; a lane strobe is honoured only while this is high.
- `line_pop_in` input 1: `memory` consumed the head line this cycle.
- `flush_in` input 1: synchronous discard of all queued and partial data.
- `write_buffer_read_out` output LINE_WIDTH: head line.
- `write_buffer_valid_out` output 1: head line present (count ≠ 0).
- `count_out` output $clog2(DEPTH+1): lines queued.
- `full_out` output 1: count == DEPTH.
- `overflow_out` output 1: sticky; a completed line was dropped.
- `conflict_out` output 1: sticky; a lane was re-strobed before its line completed.

## Operation

**Line layout** (matches `memory` read layout)
- FMA i occupies words 3i (a), 3i+1 (b), 3i+2 (c); word 0 is at the MSB.
- Word k sits at bits [LINE_WIDTH-1-k*WORD_WIDTH -: WORD_WIDTH].
- The result is written to the c slot. The a and b slots are zero.

**Assembly stage**
- Holds a partial line plus a `got[FMA_COUNT]` mask.
- Lane i is accepted when `fma_valid_in[i] && fma_output_can_be_valid_in`. Its word is stored and `got[i]` is set.
- Accepting a lane whose `got[i]` is already set overwrites the stored word and sets `conflict_out`.
- The line completes when `got | accepted` is all ones. The completed line (including same-cycle words) is pushed and the assembly is cleared the same edge.
- All lanes valid in one cycle completes a line in that cycle.

**FIFO**
- Circular buffer with read/write pointers that wrap mod DEPTH.
- A push with count<DEPTH is stored.
- A push when full with `line_pop_in` high in the same cycle is accepted (count unchanged).
- A push when full without a pop drops the line and sets `overflow_out`.
- A pop when count==0 is ignored.
- A push and pop together with 0<count<DEPTH leave count unchanged.

**Flush**
- `flush_in` has highest priority.
- Empties the FIFO, clears the assembly mask, and ignores any same-cycle push or pop.
- Does not clear the sticky flags; only reset does.

**Reset**
- Asynchronously sets pointers, count, and the `got` mask to 0, and clears `overflow_out` and `conflict_out`.
- Afterwards `write_buffer_valid_out`=0, `full_out`=0, `count_out`=0, and `write_buffer_read_out`=0 (the FIFO storage reads as 0 after reset).
- Reset in the middle of assembly discards the partial line.

## Timing

- **Latency:** a line completing at edge N is visible on `write_buffer_read_out` with `write_buffer_valid_out`=1 after edge N, provided the FIFO was empty.
- **Head output:** driven combinationally from registered storage at the read pointer; no extra register stage.
- **Pop:** `line_pop_in` sampled at edge N; the next line (or valid=0) appears after edge N.
- **Back-to-back:** one line completion per cycle is sustained indefinitely with a pop every cycle.
- **Status outputs:** `count_out`, `full_out` and the sticky flags update on the same edge as the event that causes them.

## Test plan

- **Reset:** hold `rst_in`=0 mid-cycle, then release → all outputs 0. Strobing lanes while in reset has no effect.
- **Single line:** can_be_valid=1, valid=2'b11, c={16'h0002,16'h0001} → next cycle valid_out=1 and read_out=96'h0000_0000_0001_0000_0000_0002, count=1. Pop → valid_out=0.
- **Staggered lanes:**
  - Lane 0 = 16'h00AA at cycle 1 → no line.
  - Lane 1 = 16'h00BB at cycle 3 → line 96'h0000_0000_00AA_0000_0000_00BB.
  - Lane 0 again before completion → conflict_out=1, newer value kept.
  - Strobes with can_be_valid=0 are ignored.
- **Full/overflow:** complete 4 lines without pops → full_out=1, count=4. A 5th line → dropped, overflow_out=1, head unchanged. Pop 4 times → lines 1–4 come out in order.
- **Full with simultaneous push+pop:** count stays 4. The new line is the last one popped, confirming pointer wrap-around.
- **Flush:** partial lane 0 plus 2 queued lines, then flush_in with a same-cycle push → count=0, valid_out=0. A subsequent single lane-1 strobe does not complete a line. The sticky flags persist.
